// File: rtl/ld_ecc_scalar_mult.sv
// Q = k*P on y^2 + xy = x^3 + A*x^2 + B over GF(2^N); Q returned in Lopez-Dahab (X, Y, Z).
// Define LD_ECC_CONST_TIME_EN to pad every operation to the worst-case latency (WAIT state).
module ld_ecc_scalar_mult #(
    parameter int N = 3,
    parameter int K = 4,
    parameter logic [N:0] POLY = 4'b1011,
    parameter logic [N-1:0] A = {{(N-1){1'b0}}, 1'b1},
    parameter logic [N-1:0] B = {{(N-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] k,
    input  logic [N-1:0] x_Plaintext,
    input  logic [N-1:0] y_Plaintext,
    output logic         busy,
    output logic         process_done,
    output logic [N-1:0] x_Plaintext_out,
    output logic [N-1:0] y_Plaintext_out,
    output logic [N-1:0] z_Plaintext_out
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DBL, S_ADD, S_NEXT, S_WAIT, S_DONE} state_t;

`ifdef LD_ECC_CONST_TIME_EN
    localparam int MAXLAT = K + (K - 1) * (24 * (N + 1) + 1) + 3;
    localparam int CYW = $clog2(MAXLAT + 1);
    localparam state_t S_FIN = S_WAIT;
    logic [CYW-1:0] cyc_q, cyc_d;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t         state_q, state_d;
    logic [K-1:0]   k_q, k_d;
    logic [N-1:0]   px_q, px_d, py_q, py_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic [N-1:0]   t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     op_q, op_d;
    logic [IW-1:0]  i_q, i_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [N-1:0]   xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    logic [N-1:0]   op_a, op_b, acc_base, acc_sh, acc_step, res;
    logic [CW-1:0]  b_idx;
    logic [3:0]     last_op;

    always_comb begin
        state_d = state_q;
        k_d = k_q;   px_d = px_q; py_d = py_q;
        x_d = x_q;   y_d = y_q;   z_d = z_q;
        t0_d = t0_q; t1_d = t1_q; t2_d = t2_q; t3_d = t3_q;
        acc_d = acc_q; cnt_d = cnt_q; op_d = op_q; i_d = i_q;
        busy_d = busy_q; done_d = 1'b0;
        xo_d = xo_q; yo_d = yo_q; zo_d = zo_q;
`ifdef LD_ECC_CONST_TIME_EN
        cyc_d = (state_q == S_IDLE) ? cyc_q : cyc_q + 1'b1;
`endif
        op_a = '0;
        op_b = '0;
        last_op = (state_q == S_DBL) ? 4'd9 : 4'd13;

        // Operand routing for the shared multiplier; temporaries t0..t3 are reused per step.
        if (state_q == S_DBL) begin
            case (op_q)
                4'd0:    begin op_a = x_q; op_b = x_q; end
                4'd1:    begin op_a = z_q; op_b = z_q; end
                4'd2:    begin op_a = t0_q; op_b = t1_q; end
                4'd3:    begin op_a = t0_q; op_b = t0_q; end
                4'd4:    begin op_a = t1_q; op_b = t1_q; end
                4'd5:    begin op_a = B; op_b = t1_q; end
                4'd6:    begin op_a = A; op_b = z_q; end
                4'd7:    begin op_a = y_q; op_b = y_q; end
                4'd8:    begin op_a = t1_q; op_b = z_q; end
                default: begin op_a = x_q; op_b = t2_q ^ t3_q ^ t1_q; end
            endcase
        end else if (state_q == S_ADD) begin
            case (op_q)
                4'd0:    begin op_a = z_q; op_b = z_q; end
                4'd1:    begin op_a = py_q; op_b = t0_q; end
                4'd2:    begin op_a = px_q; op_b = z_q; end
                4'd3:    begin op_a = z_q; op_b = t2_q; end
                4'd4:    begin op_a = t2_q; op_b = t2_q; end
                4'd5:    begin op_a = A; op_b = t0_q; end
                4'd6:    begin op_a = t2_q; op_b = t3_q ^ t0_q; end
                4'd7:    begin op_a = t3_q; op_b = t3_q; end
                4'd8:    begin op_a = t1_q; op_b = t3_q; end
                4'd9:    begin op_a = t1_q; op_b = t1_q; end
                4'd10:   begin op_a = px_q; op_b = z_q; end
                4'd11:   begin op_a = z_q; op_b = z_q; end
                4'd12:   begin op_a = px_q ^ py_q; op_b = t1_q; end
                default: begin op_a = t3_q ^ z_q; op_b = t0_q; end
            endcase
        end

        // MSB-first shift-and-add; the accumulator restarts from zero on the first step.
        acc_base = (cnt_q == '0) ? '0 : acc_q;
        acc_sh   = {acc_base[N-2:0], 1'b0} ^ (acc_base[N-1] ? POLY[N-1:0] : '0);
        b_idx    = (cnt_q < CW'(N)) ? CW'(N - 1) - cnt_q : '0;
        acc_step = acc_sh ^ (op_b[b_idx] ? op_a : '0);
        res      = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d = k; px_d = x_Plaintext; py_d = y_Plaintext;
                    i_d = IW'(K - 1);
                    busy_d = 1'b1;
                    state_d = S_SCAN;
`ifdef LD_ECC_CONST_TIME_EN
                    cyc_d = '0;
`endif
                end
            end
            S_SCAN: begin
                cnt_d = '0;
                op_d = '0;
                if (k_q[i_q]) begin
                    x_d = px_q; y_d = py_q; z_d = ONE;
                    if (i_q == '0) state_d = S_FIN;
                    else begin
                        i_d = i_q - 1'b1;
                        state_d = S_DBL;
                    end
                end else if (i_q == '0) begin
                    x_d = ONE; y_d = '0; z_d = '0;
                    state_d = S_FIN;
                end else begin
                    i_d = i_q - 1'b1;
                end
            end
            S_DBL, S_ADD: begin
                if (cnt_q != CW'(N)) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    op_d = op_q + 1'b1;
                    if (state_q == S_DBL) begin
                        case (op_q)
                            4'd0:    t0_d = res;
                            4'd1:    t1_d = res;
                            4'd2:    z_d = res;
                            4'd3:    t0_d = res;
                            4'd4:    t1_d = res;
                            4'd5:    begin t1_d = res; x_d = t0_q ^ res; end
                            4'd6:    t2_d = res;
                            4'd7:    t3_d = res;
                            4'd8:    t0_d = res;
                            default: y_d = t0_q ^ res;
                        endcase
                    end else begin
                        case (op_q)
                            4'd0:    t0_d = res;
                            4'd1:    t1_d = res ^ y_q;
                            4'd2:    t2_d = res ^ x_q;
                            4'd3:    t3_d = res;
                            4'd4:    t2_d = res;
                            4'd5:    t0_d = res;
                            4'd6:    t2_d = res;
                            4'd7:    z_d = res;
                            4'd8:    t3_d = res;
                            4'd9:    x_d = res ^ t2_q ^ t3_q;
                            4'd10:   t0_d = res ^ x_q;
                            4'd11:   t1_d = res;
                            4'd12:   t1_d = res;
                            default: y_d = res ^ t1_q;
                        endcase
                    end
                    if (op_q == last_op) begin
                        op_d = '0;
                        if (state_q == S_DBL && k_q[i_q]) state_d = S_ADD;
                        else state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (i_q == '0) state_d = S_FIN;
                else begin
                    i_d = i_q - 1'b1;
                    state_d = S_DBL;
                end
            end
            S_WAIT: begin
`ifdef LD_ECC_CONST_TIME_EN
                if (cyc_q >= CYW'(MAXLAT - 3)) state_d = S_DONE;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                xo_d = x_q; yo_d = y_q; zo_d = z_q;
                done_d = 1'b1;
                busy_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q <= '0; px_q <= '0; py_q <= '0;
            x_q <= '0; y_q <= '0; z_q <= '0;
            t0_q <= '0; t1_q <= '0; t2_q <= '0; t3_q <= '0;
            acc_q <= '0; cnt_q <= '0; op_q <= '0; i_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0;
            xo_q <= '0; yo_q <= '0; zo_q <= '0;
`ifdef LD_ECC_CONST_TIME_EN
            cyc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q <= k_d; px_q <= px_d; py_q <= py_d;
            x_q <= x_d; y_q <= y_d; z_q <= z_d;
            t0_q <= t0_d; t1_q <= t1_d; t2_q <= t2_d; t3_q <= t3_d;
            acc_q <= acc_d; cnt_q <= cnt_d; op_q <= op_d; i_q <= i_d;
            busy_q <= busy_d; done_q <= done_d;
            xo_q <= xo_d; yo_q <= yo_d; zo_q <= zo_d;
`ifdef LD_ECC_CONST_TIME_EN
            cyc_q <= cyc_d;
`endif
        end
    end

    assign busy            = busy_q;
    assign process_done    = done_q;
    assign x_Plaintext_out = xo_q;
    assign y_Plaintext_out = yo_q;
    assign z_Plaintext_out = zo_q;
endmodule

// File: tb/tb_ld_ecc_scalar_mult.sv
// Randomized bench for ld_ecc_scalar_mult against a formula-level LD double-and-add model.
module tb_ld_ecc_scalar_mult;
    localparam int N = 3;
    localparam int K = 4;
    localparam int POLY = 11;
    localparam int CA = 1;
    localparam int CB = 1;
    localparam int MAXLAT = K + (K - 1) * (24 * (N + 1) + 1) + 3;

    logic clk = 1'b0;
    logic reset, start;
    logic [K-1:0] k;
    logic [N-1:0] x_in, y_in;
    logic busy, process_done;
    logic [N-1:0] xo, yo, zo;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, pending = 0, pd_count = 0;
    int exp_x = 0, exp_y = 0, exp_z = 0, exp_lat = 0;

    ld_ecc_scalar_mult dut (
        .clk(clk), .reset(reset), .start(start), .k(k),
        .x_Plaintext(x_in), .y_Plaintext(y_in),
        .busy(busy), .process_done(process_done),
        .x_Plaintext_out(xo), .y_Plaintext_out(yo), .z_Plaintext_out(zo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int gm(input int a, input int b);
        int p = 0;
        for (int j = 0; j < N; j++) if (((b >> j) & 1) != 0) p ^= a << j;
        for (int d = 2 * N - 2; d >= N; d--) if (((p >> d) & 1) != 0) p ^= POLY << (d - N);
        return p;
    endfunction

    task automatic model(input int kk, input int px, input int py,
                         output int qx, output int qy, output int qz, output int lat);
        int top = -1;
        int x1, y1, z1, z1s, x2, z2, z3, x4, z4, bz4, x3, y3, ap, bp, c, d, e, f, g;
        for (int b = 0; b < K; b++) if (((kk >> b) & 1) != 0) top = b;
        if (top < 0) begin
            qx = 1; qy = 0; qz = 0;
            lat = K + 2;
        end else begin
            x1 = px; y1 = py; z1 = 1;
            lat = (K - top) + 2;
            for (int i = top - 1; i >= 0; i--) begin
                x2 = gm(x1, x1); z2 = gm(z1, z1); z3 = gm(x2, z2);
                x4 = gm(x2, x2); z4 = gm(z2, z2); bz4 = gm(CB, z4);
                x3 = x4 ^ bz4;
                y3 = gm(bz4, z3) ^ gm(x3, gm(CA, z3) ^ gm(y1, y1) ^ bz4);
                x1 = x3; y1 = y3; z1 = z3;
                lat += 10 * (N + 1) + 1;
                if (((kk >> i) & 1) != 0) begin
                    z1s = gm(z1, z1);
                    ap = gm(py, z1s) ^ y1;
                    bp = gm(px, z1) ^ x1;
                    c = gm(z1, bp);
                    d = gm(gm(bp, bp), c ^ gm(CA, z1s));
                    z3 = gm(c, c);
                    e = gm(ap, c);
                    x3 = gm(ap, ap) ^ d ^ e;
                    f = x3 ^ gm(px, z3);
                    g = gm(px ^ py, gm(z3, z3));
                    y3 = gm(e ^ z3, f) ^ g;
                    x1 = x3; y1 = y3; z1 = z3;
                    lat += 14 * (N + 1);
                end
            end
            qx = x1; qy = y1; qz = z1;
        end
`ifdef LD_ECC_CONST_TIME_EN
        lat = MAXLAT;
`endif
    endtask

    // Compare process: checks every done pulse and busy on every cycle of an operation.
    always @(negedge clk) begin
        if (!reset) begin
            if (process_done) begin
                pd_count++;
                if (pending == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("q_x", int'(xo), exp_x);
                    chk("q_y", int'(yo), exp_y);
                    chk("q_z", int'(zo), exp_z);
                    chk("latency", cyc - start_cyc + 1, exp_lat);
                    chk("busy_at_done", int'(busy), 0);
                    pending = 0;
                end
            end else if (pending != 0 && cyc >= start_cyc) begin
                chk("busy_during_op", int'(busy), 1);
            end
        end
    end

    task automatic run_op(input int kk, input int px, input int py, input bit hold);
        int ex, ey, ez, el, waited;
        @(negedge clk);
        model(kk, px, py, ex, ey, ez, el);
        exp_x = ex; exp_y = ey; exp_z = ez; exp_lat = el;
        start_cyc = cyc + 1;
        pending = 1;
        start = 1'b1; k = K'(kk); x_in = N'(px); y_in = N'(py);
        @(negedge clk);
        if (!hold) start = 1'b0;
        waited = 0;
        while (pending != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (hold && !busy) start = 1'b0;
        end
        start = 1'b0;
        if (pending != 0) begin
            chk("done_timeout", waited, -1);
            pending = 0;
        end
        $display("op k=%0d P=(%0d,%0d) -> Q=(%0d,%0d,%0d) expected (%0d,%0d,%0d) hold=%0d",
                 kk, px, py, xo, yo, zo, ex, ey, ez, hold);
    endtask

    initial begin
        int mx, my, mz, ml, pd_before;
        reset = 1'b1; start = 1'b0; k = '0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(process_done), 0);
        chk("rst_x", int'(xo), 0);
        chk("rst_y", int'(yo), 0);
        chk("rst_z", int'(zo), 0);
        reset = 1'b0;

        // Hand-derived points on y^2+xy=x^3+x^2+1 over GF(8) pin the model.
        model(0, 3, 3, mx, my, mz, ml);
        chk("model_k0", mx * 64 + my * 8 + mz, 1 * 64 + 0 * 8 + 0);
        model(1, 3, 3, mx, my, mz, ml);
        chk("model_k1", mx * 64 + my * 8 + mz, 3 * 64 + 3 * 8 + 1);
        model(2, 3, 3, mx, my, mz, ml);
        chk("model_k2", mx * 64 + my * 8 + mz, 6 * 64 + 3 * 8 + 5);
        model(3, 3, 3, mx, my, mz, ml);
        chk("model_k3", mx * 64 + my * 8 + mz, 5 * 64 + 0 * 8 + 1);
`ifndef LD_ECC_CONST_TIME_EN
        model(0, 3, 3, mx, my, mz, ml);
        chk("model_lat_k0", ml, 6);
`endif

        run_op(0, 3, 3, 1'b0);
        run_op(1, 3, 3, 1'b0);
        run_op(2, 3, 3, 1'b0);
        run_op(3, 3, 3, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold_x", int'(xo), 5);
        chk("hold_y", int'(yo), 0);
        chk("hold_z", int'(zo), 1);

        pd_before = pd_count;
        run_op(3, 3, 3, 1'b1);
        repeat (20) @(negedge clk);
        chk("held_start_one_op", pd_count - pd_before, 1);
        chk("held_start_idle", int'(busy), 0);

        for (int n = 0; n < 20; n++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 1'b0);
        run_op(15, 7, 7, 1'b0);

        // Abort mid-doubling.
        @(negedge clk);
        start_cyc = cyc + 1;
        pending = 1;
        start = 1'b1; k = 4'd15; x_in = 3'd5; y_in = 3'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_before_rst", int'(busy), 1);
        pd_before = pd_count;
        pending = 0;
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_x", int'(xo), 0);
        chk("abort_y", int'(yo), 0);
        chk("abort_z", int'(zo), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        chk("abort_no_done", pd_count - pd_before, 0);
        chk("abort_idle_busy", int'(busy), 0);

        run_op(2, 3, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
